booth_mult_seq: RTL and testbench

- Parametrised, handshaked, iterative radix-2 Booth multiplier. Successor to the fixed 4-bit Booth multiplier.
- Generalised to WIDTH-bit operands, with a per-transaction signed/unsigned mode.
- Uses valid/ready on input and output, so it sits directly in a datapath pipeline with back-pressure.
- Produces one exact 2*WIDTH-bit product per accepted operand pair.

---
 rtl/booth_pkg.sv | 24 ++
 rtl/booth_step.sv | 30 +++
 rtl/booth_mult_seq.sv | 126 ++++++++++++
 tb/tb_booth_mult_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM state encoding,
// Booth operation encodings and the recoding helper that selects one.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

    // Radix-2 Booth recoding of the pair {Q[0], q_m1}.
    function automatic logic [1:0] booth_op(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration on N-bit registers: optional add or
// subtract of M into A, then a 1-bit arithmetic shift right of {A, Q, q_m1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] m,
    input  logic [N-1:0] q,
    input  logic         q_m1,
    output logic [N-1:0] a_next,
    output logic [N-1:0] q_next,
    output logic         q_m1_next
);

    logic [N-1:0] sum;

    always_comb begin
        case (booth_op(q[0], q_m1))
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
        a_next    = {sum[N-1], sum[N-1:1]};
        q_next    = {sum[0], q[N-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Handshaked iterative radix-2 Booth multiplier, WIDTH-bit signed/unsigned operands,
// exact 2*WIDTH-bit product. Define BOOTH_EARLY_TERM_EN for data-dependent early exit.
//
// Handshake: an input pair transfers on a rising edge with i_valid && o_ready; a
// product transfers on a rising edge with o_valid && i_ready. o_product is held
// stable while o_valid is high and i_ready is low.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    input  logic               i_signed,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_product,
    output logic               o_busy
);

    localparam int N = WIDTH + 1;

    booth_state_t state, state_next;

    logic [N-1:0]     a, q, m;
    logic             q_m1;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0] a_step, q_step;
    logic         q_m1_step;
    logic [N-1:0] m_ext, q_ext;
    logic         accept;
    logic         last_step;
    logic         start_done;
    logic         calc_done;
    logic [2*N:0] calc_next;

    // One extra bit of headroom keeps most-negative and all-ones operands exact.
    assign m_ext = {i_signed & i_multiplicand[WIDTH-1], i_multiplicand};
    assign q_ext = {i_signed & i_multiplier[WIDTH-1], i_multiplier};

    assign accept    = i_valid && o_ready;
    assign last_step = (cnt == CNT_W'(1));

    booth_step #(.N(N)) u_step (
        .a         (a),
        .m         (m),
        .q         (q),
        .q_m1      (q_m1),
        .a_next    (a_step),
        .q_next    (q_step),
        .q_m1_next (q_m1_step)
    );

`ifdef BOOTH_EARLY_TERM_EN
    logic [N-1:0] rem_mask;
    logic         skip_rest;
    logic [2*N:0] shifted;

    // Remaining Booth pairs are all 00 or all 11: only shifts are left to do.
    assign rem_mask   = ~({N{1'b1}} << cnt);
    assign skip_rest  = q_m1 ? (&(q | ~rem_mask)) : ~(|(q & rem_mask));
    assign shifted    = $signed({a, q, q_m1}) >>> cnt;
    assign start_done = ~(|q_ext);
    assign calc_done  = last_step || skip_rest;
    assign calc_next  = skip_rest ? shifted : {a_step, q_step, q_m1_step};
`else
    assign start_done = 1'b0;
    assign calc_done  = last_step;
    assign calc_next  = {a_step, q_step, q_m1_step};
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = start_done ? DONE : CALC;
            CALC: if (calc_done) state_next = DONE;
            DONE: if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
        o_busy  = (state == CALC) || (state == DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a    <= '0;
            q    <= '0;
            m    <= '0;
            q_m1 <= 1'b0;
            cnt  <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                a    <= '0;
                q    <= q_ext;
                m    <= m_ext;
                q_m1 <= 1'b0;
                cnt  <= CNT_W'(N);
            end
        end else if (state == CALC) begin
            {a, q, q_m1} <= calc_next;
            cnt          <= cnt - CNT_W'(1);
        end
    end

    // Low 2*WIDTH bits of {A, Q}.
    assign o_product = {a[WIDTH-2:0], q};

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: WIDTH=4 directed products plus a WIDTH=8 instance
// checked every cycle against an arithmetic reference model.
module tb_booth_mult_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       v4, or4, s4, ov4, ir4, busy4;
    logic [3:0] m4, q4;
    logic [7:0] p4;

    logic        v8, or8, s8, ov8, ir8, busy8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;

    booth_mult_seq #(.WIDTH(4)) u4 (
        .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(or4),
        .i_multiplicand(m4), .i_multiplier(q4), .i_signed(s4),
        .o_valid(ov4), .i_ready(ir4), .o_product(p4), .o_busy(busy4)
    );

    booth_mult_seq #(.WIDTH(8)) u8 (
        .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(or8),
        .i_multiplicand(m8), .i_multiplier(q8), .i_signed(s8),
        .o_valid(ov8), .i_ready(ir8), .o_product(p8), .o_busy(busy8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    int          accepts8     = 0;
    int          cyc          = 0;
    int          last_acc_cyc = -1;
    bit          tput_chk     = 1'b0;
    bit          hold_prev    = 1'b0;
    logic [15:0] held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model8(input logic [7:0] m, input logic [7:0] q, input logic s);
        longint x, y;
        x = s ? longint'($signed(m)) : longint'(m);
        y = s ? longint'($signed(q)) : longint'(q);
        return 16'(x * y);
    endfunction

    function automatic logic [7:0] model4(input logic [3:0] m, input logic [3:0] q, input logic s);
        longint x, y;
        x = s ? longint'($signed(m)) : longint'(m);
        y = s ? longint'($signed(q)) : longint'(q);
        return 8'(x * y);
    endfunction

    // Scoreboard for the 8-bit instance, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            check("ready_vs_busy8", 64'(or8), 64'(!busy8));
            check("valid_implies_busy8", 64'(ov8 && !busy8), 64'd0);
            if (ov8 && hold_prev) check("hold_stable8", 64'(p8), 64'(held));
            if (ov8 && ir8) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_product8: got %0h with empty queue", p8);
                end else begin
                    check("product8", 64'(p8), 64'(exp_q.pop_front()));
                end
            end
            hold_prev = ov8 && !ir8;
            held      = p8;
            if (v8 && or8) begin
                exp_q.push_back(model8(m8, q8, s8));
                accepts8++;
                if (tput_chk && last_acc_cyc >= 0) check("interval8", 64'(cyc - last_acc_cyc), 64'd11);
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic op4(input logic [3:0] m, input logic [3:0] q, input logic s,
                       input logic [7:0] exp, input string name);
        int guard = 0;
        int lat   = 0;
        @(posedge clk); #1;
        m4 = m; q4 = q; s4 = s; v4 = 1'b1; ir4 = 1'b0;
        while (!or4 && guard < 100) begin @(posedge clk); #1; guard++; end
        check({name, "_ready"}, 64'(or4), 64'd1);
        @(posedge clk); #1;
        v4 = 1'b0;
        while (!ov4 && lat < 100) begin @(posedge clk); #1; lat++; end
        check({name, "_latency"}, 64'(lat), 64'd5);
        check(name, 64'(p4), 64'(exp));
        ir4 = 1'b1;
        @(posedge clk); #1;
        ir4 = 1'b0;
        check({name, "_ready_after"}, 64'(or4), 64'd1);
    endtask

    task automatic op8(input logic [7:0] m, input logic [7:0] q, input logic s,
                       input logic [15:0] exp, input int hold, input string name);
        int guard = 0;
        int lat   = 0;
        @(posedge clk); #1;
        m8 = m; q8 = q; s8 = s; v8 = 1'b1; ir8 = 1'b0;
        while (!or8 && guard < 100) begin @(posedge clk); #1; guard++; end
        check({name, "_ready"}, 64'(or8), 64'd1);
        @(posedge clk); #1;
        v8 = 1'b0;
        m8 = ~m; q8 = ~q; s8 = ~s;
        while (!ov8 && lat < 100) begin @(posedge clk); #1; lat++; end
        check({name, "_latency"}, 64'(lat), 64'd9);
        check(name, 64'(p8), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 64'(ov8), 64'd1);
            check({name, "_hold_prod"}, 64'(p8), 64'(exp));
        end
        ir8 = 1'b1;
        @(posedge clk); #1;
        ir8 = 1'b0;
        check({name, "_ready_after"}, 64'(or8), 64'd1);
        check({name, "_valid_after"}, 64'(ov8), 64'd0);
    endtask

    logic [7:0] corners [4] = '{8'h00, 8'h80, 8'hFF, 8'h7F};

    function automatic logic [7:0] rnd_operand();
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        int target;
        int guard;
        rst = 1'b1;
        v4 = 1'b0; ir4 = 1'b0; m4 = '0; q4 = '0; s4 = 1'b0;
        v8 = 1'b0; ir8 = 1'b0; m8 = '0; q8 = '0; s8 = 1'b0;
        #1;
        check("rst_ready4", 64'(or4), 64'd1);
        check("rst_valid4", 64'(ov4), 64'd0);
        check("rst_busy4", 64'(busy4), 64'd0);
        check("rst_product4", 64'(p4), 64'd0);
        check("rst_ready8", 64'(or8), 64'd1);
        check("rst_valid8", 64'(ov8), 64'd0);
        check("rst_busy8", 64'(busy8), 64'd0);
        check("rst_product8", 64'(p8), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        check("model_pin_ff_ff", 64'(model8(8'hFF, 8'hFF, 1'b0)), 64'h0000_FE01);
        check("model_pin_m8_m8", 64'(model4(4'h8, 4'h8, 1'b1)), 64'h40);
        check("model_pin_7_m7", 64'(model4(4'h7, 4'h9, 1'b1)), 64'hCF);

        op4(4'd7, 4'd9, 1'b0, 8'h3F, "u4_7x9");
        op4(4'd7, 4'h9, 1'b1, 8'hCF, "s4_7xm7");
        op4(4'h8, 4'h8, 1'b1, 8'h40, "s4_m8xm8");
        op4(4'hF, 4'hF, 1'b0, 8'hE1, "u4_15x15");

        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 10, "u8_255x255");
        op8(8'h80, 8'h80, 1'b1, 16'h4000, 0, "s8_m128xm128");
        op8(8'h80, 8'h7F, 1'b1, 16'hC080, 0, "s8_m128x127");

        // Reset abandoned in the third CALC cycle.
        @(posedge clk); #1;
        m8 = 8'd100; q8 = 8'd100; s8 = 1'b0; v8 = 1'b1;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid8", 64'(ov8), 64'd0);
        check("midrst_ready8", 64'(or8), 64'd1);
        check("midrst_busy8", 64'(busy8), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        op8(8'd3, 8'd5, 1'b0, 16'd15, 0, "u8_3x5_after_rst");

        // Back-to-back with i_ready held high.
        @(posedge clk); #1;
        ir8 = 1'b1; v8 = 1'b1;
        last_acc_cyc = -1;
        tput_chk = 1'b1;
        target = accepts8 + 700;
        guard = 0;
        while (accepts8 < target && guard < 20000) begin
            m8 = rnd_operand(); q8 = rnd_operand(); s8 = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            guard++;
        end
        check("phase1_accepts", 64'(accepts8 >= target), 64'd1);
        tput_chk = 1'b0;

        // Random downstream back-pressure.
        target = accepts8 + 300;
        guard = 0;
        while (accepts8 < target && guard < 20000) begin
            m8 = rnd_operand(); q8 = rnd_operand(); s8 = 1'($urandom_range(0, 1));
            ir8 = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            guard++;
        end
        check("phase2_accepts", 64'(accepts8 >= target), 64'd1);

        v8 = 1'b0; ir8 = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin @(posedge clk); #1; guard++; end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
